// File: rtl/filt_pkg.sv
//------------------------------------------------------------------------------
// Module      : filt_pkg
// Description : Shared state encodings and run-length limits for the 3-sample
//               glitch filter and its pulse transmitter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package filt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } filt_state_e;

  localparam int FILT_MIN_RUN = 3;

  function automatic int filt_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Both runs must outlast the receiver's filter window.
  function automatic bit filt_runs_ok(input int high_len, input int low_len);
    return (high_len >= FILT_MIN_RUN) && (low_len >= FILT_MIN_RUN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/filt_tx_if.sv
//------------------------------------------------------------------------------
// Module      : filt_tx_if
// Description : Command handshake and event-line bundle of the pulse
//               transmitter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface filt_tx_if #(
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_ready;
  logic             y;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_cnt,
    input  cmd_ready, y, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_cnt,
    output cmd_ready, y, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/filt_run_timer.sv
//------------------------------------------------------------------------------
// Module      : filt_run_timer
// Description : Loadable down-counter timing one HIGH or LOW run; holds at 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module filt_run_timer #(
  parameter int W = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         load,
  input  wire logic [W-1:0] load_val,
  output logic              zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/filt_tx.sv
//------------------------------------------------------------------------------
// Module      : filt_tx
// Description : Pulse-burst transmitter; each pulse is HIGH_LEN high then
//               LOW_LEN low so a 3-sample filter sees exactly one event.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module filt_tx
  import filt_pkg::*;
#(
  parameter int HIGH_LEN = 4,
  parameter int LOW_LEN  = 4,
  parameter int CNT_W    = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  filt_tx_if.slave  bus
);

  localparam int TW = $clog2(filt_max(HIGH_LEN, LOW_LEN));
  localparam logic [TW-1:0] C_HIGH_LD = TW'(HIGH_LEN - 1);
  localparam logic [TW-1:0] C_LOW_LD  = TW'(LOW_LEN - 1);

  generate
    if (!filt_runs_ok(HIGH_LEN, LOW_LEN)) begin : g_bad_runs
      $error("filt_tx: HIGH_LEN and LOW_LEN must be >= %0d", FILT_MIN_RUN);
    end
  endgenerate

  filt_state_e      r_state;
  logic [CNT_W-1:0] r_remaining;
  logic             r_y;
  logic             r_busy;
  logic             r_done;

  logic             w_ready;
  logic             w_accept;
  logic             w_zero;
  logic             w_load;
  logic [TW-1:0]    w_load_val;

  assign w_ready  = (r_state == ST_IDLE);
  assign w_accept = bus.cmd_valid && w_ready;

  // The timer is reloaded at every run boundary that leads into another run.
  assign w_load = (w_accept && (bus.cmd_cnt != '0))
               || ((r_state == ST_HIGH) && w_zero)
               || ((r_state == ST_LOW) && w_zero && (r_remaining != '0));
  assign w_load_val = (r_state == ST_HIGH) ? C_LOW_LD : C_HIGH_LD;

  filt_run_timer #(
    .W (TW)
  ) u_run_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_y         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_y    <= 1'b0;
          r_busy <= 1'b0;
          if (w_accept) begin
            if (bus.cmd_cnt != '0) begin
              r_remaining <= bus.cmd_cnt;
              r_state     <= ST_HIGH;
              r_y         <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_HIGH: begin
          if (w_zero) begin
            r_remaining <= r_remaining - CNT_W'(1);
            r_state     <= ST_LOW;
            r_y         <= 1'b0;
          end
        end
        ST_LOW: begin
          // The trailing low run always completes before returning to idle.
          if (w_zero) begin
            if (r_remaining != '0) begin
              r_state <= ST_HIGH;
              r_y     <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_y     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.y         = r_y;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: doc/filt_tx.md
# filt_tx

Pulse-burst transmitter that drives a single-wire event line. Every pulse is held high and then low for at least 3 clock samples, so the 3-sample glitch filter at the receiving end registers exactly one event per pulse. A command supplies a pulse count through a valid/ready handshake. The block emits that many pulses and signals completion with a one-cycle `done`. It sits on the sending side of a link whose receiving end is the team's 3-sample filter.

## Interface

Parameters:
- `HIGH_LEN`, default 4: high run per pulse, in cycles. Must be ≥ 3.
- `LOW_LEN`, default 4: low run per pulse, in cycles. Must be ≥ 3.
- `CNT_W`, default 4: width of the pulse count. Allows up to 2^CNT_W−1 pulses per command.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_cnt`  in  CNT_W  number of pulses to send. 0 is a no-op command.
- `cmd_ready`  out  1  high when the block can accept a command. Equals (state == IDLE).
- `y`  out  1  event line. Registered.
- `busy`  out  1  high in HIGH or LOW state. Registered.
- `done`  out  1  one-cycle pulse when a command completes. Registered.

## Operation

- States:
  - IDLE: `y`=0, `cmd_ready`=1.
  - HIGH: `y`=1.
  - LOW: `y`=0.
- Reset values: state IDLE, `y`=0, `busy`=0, `done`=0, remaining count 0, run timer 0.
- Acceptance happens on a rising edge where `cmd_valid` && `cmd_ready`.
- Accept with `cmd_cnt`≠0:
  - load remaining = `cmd_cnt`;
  - load timer = HIGH_LEN−1;
  - go to HIGH.
- Accept with `cmd_cnt`=0: stay in IDLE and pulse `done` in the next cycle. `cmd_ready` stays 1.
- HIGH: decrement the timer each cycle. When timer = 0:
  - load timer = LOW_LEN−1;
  - decrement remaining;
  - go to LOW.
- LOW: decrement the timer each cycle. When timer = 0:
  - if remaining ≠ 0: load timer = HIGH_LEN−1 and go to HIGH;
  - if remaining = 0: go to IDLE and set `done`=1 for one cycle.
- The trailing LOW run always completes, including on the last pulse. This guarantees the receiver's filter releases before the next burst.
- `cmd_cnt` is sampled only at acceptance. Later changes on `cmd_cnt` are ignored.
- `cmd_valid` while busy is ignored. The command is not lost: it is simply not accepted until the block is back in IDLE.
- Default case: any illegal state goes to IDLE with `y`=0.
- Reset mid-operation: `y`, `busy` and `done` drop to 0 asynchronously, the state goes to IDLE, and no `done` is produced for the aborted command.

## Timing

- Let E0 be the acceptance edge.
- `y`=1 and `busy`=1 in the first cycle after E0. There are no idle cycles between acceptance and the first high.
- Each pulse is exactly HIGH_LEN cycles high followed by exactly LOW_LEN cycles low.
- The burst occupies `cmd_cnt`×(HIGH_LEN+LOW_LEN) cycles after E0.
- In the next cycle `done`=1, `busy`=0 and `cmd_ready`=1.
- Back-to-back commands: a command held valid is accepted at the edge that ends the `done` cycle. The low gap between bursts is then exactly LOW_LEN+1 cycles.
- Zero-count command: `done`=1 in the cycle after E0, and `y` never toggles.
- Width rules:
  - run timer width = clog2(max(HIGH_LEN, LOW_LEN)) bits;
  - remaining counter width = CNT_W;
  - no wrap is possible, because remaining is only decremented from nonzero values.

## Structure

- Shared package `filt_pkg`:
  - state encodings `ST_IDLE`=2'd0, `ST_HIGH`=2'd1, `ST_LOW`=2'd2;
  - `FILT_MIN_RUN`=3, used by both the filter and this transmitter;
  - elaboration check that HIGH_LEN ≥ FILT_MIN_RUN and LOW_LEN ≥ FILT_MIN_RUN.
- One sub-module `filt_run_timer`: a down-counter with `load` and `load_val` inputs and a `zero` flag. It is reused for the HIGH and LOW runs.
- All other logic stays in `filt_tx`: the FSM, the remaining counter and the output registers.

## Test plan

1. **Reset.** Assert `rst` mid-simulation → `y`=0, `busy`=0, `done`=0 and `cmd_ready`=1 immediately, without waiting for a clock edge.
2. **Single pulse, HIGH_LEN=4, LOW_LEN=4, `cmd_cnt`=1.** `y` is high in cycles 1–4 after E0 and low in cycles 5–8. `done` is high in cycle 9 only. `cmd_ready` is low in cycles 1–8.
3. **Three-pulse burst, `cmd_cnt`=3, with `y` looped into the 3-sample filter.** Expect exactly 3 rising edges on the filter output, 24 busy cycles and a single `done`.
4. **Zero-count command, `cmd_cnt`=0.** `y` stays 0, `busy` stays 0, `done`=1 in cycle 1, and `cmd_ready` never drops.
5. **Reset mid-burst.** With `cmd_cnt`=5, assert `rst` during the HIGH phase of pulse 2. `y` goes to 0 immediately and no `done` is produced. A new command with `cmd_cnt`=1 then produces one clean pulse.
6. **Back-to-back commands.** Hold `cmd_valid` with `cmd_cnt`=15, then `cmd_cnt`=2. The second command is accepted in the `done` cycle of the first, the low gap is exactly 5 cycles, and 17 total pulses are seen.
